// File: rtl/lift53_step_pipe.sv
// Three-stage 5/3 (LeGall) lifting-step engine: one predict/update step, forward or inverse,
// with valid/ready flow control, symmetric edge extension, optional saturation and sticky overflow.
module lift53_step_pipe #(
  parameter int W     = 24,
  parameter bit SAT   = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_left,
  input  logic signed [W-1:0] x_center,
  input  logic signed [W-1:0] x_right,
  input  logic                edge_l,
  input  logic                edge_r,
  input  logic                even_odd,
  input  logic                fwd_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y,
  output logic                ovf,
  output logic [CNT_W-1:0]    sample_cnt
);

  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {3'b111, {(W-1){1'b0}}};

  function automatic logic out_of_range(input logic signed [XW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [W-1:0] fit_w(input logic signed [XW-1:0] v);
    if (SAT && (v > MAXV)) return MAXV[W-1:0];
    if (SAT && (v < MINV)) return MINV[W-1:0];
    return v[W-1:0];
  endfunction

  logic                 w_en;
  logic                 w_accept;
  logic signed [W-1:0]  w_l;
  logic signed [W-1:0]  w_r;

  logic                 r_vld_p1;
  logic signed [W-1:0]  r_l_p1;
  logic signed [W-1:0]  r_c_p1;
  logic signed [W-1:0]  r_r_p1;
  logic                 r_eo_p1;
  logic                 r_fi_p1;

  logic signed [XW-1:0] w_sum;
  logic signed [XW-1:0] w_sum_rnd;
  logic signed [XW-1:0] w_t;

  logic                 r_vld_p2;
  logic signed [XW-1:0] r_t_p2;
  logic signed [XW-1:0] r_c_p2;
  logic                 r_sub_p2;

  logic signed [XW-1:0] w_res;
  logic                 r_vld_p3;
  logic signed [W-1:0]  r_y_p3;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_cnt;

  // A full output register that is not being taken freezes every stage.
  assign w_en     = !r_vld_p3 || out_ready;
  assign in_ready = w_en && rst_n;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_l = x_left;
    w_r = x_right;
    if (edge_l && edge_r) begin
      w_l = x_center;
      w_r = x_center;
    end else if (edge_l) begin
      w_l = x_right;
    end else if (edge_r) begin
      w_r = x_left;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else if (w_en) begin
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // S1: edge-substituted operands and mode bits
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_l_p1  <= w_l;
      r_c_p1  <= x_center;
      r_r_p1  <= w_r;
      r_eo_p1 <= even_odd;
      r_fi_p1 <= fwd_inv;
    end
  end

  assign w_sum     = {{2{r_l_p1[W-1]}}, r_l_p1} + {{2{r_r_p1[W-1]}}, r_r_p1};
  assign w_sum_rnd = w_sum + XW'(2);
  assign w_t       = r_eo_p1 ? (w_sum_rnd >>> 2) : (w_sum >>> 1);

  // S2: floor-shifted neighbour term; subtract for forward predict and inverse update
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_t_p2   <= w_t;
      r_c_p2   <= {{2{r_c_p1[W-1]}}, r_c_p1};
      r_sub_p2 <= r_eo_p1 ^ r_fi_p1;
    end
  end

  assign w_res = r_sub_p2 ? (r_c_p2 - r_t_p2) : (r_c_p2 + r_t_p2);

  // S3: output register, overflow flag and delivery counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_p3 <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_en && r_vld_p2) r_y_p3 <= fit_w(w_res);
      if (clr) r_ovf <= 1'b0;
      else if (w_en && r_vld_p2 && out_of_range(w_res)) r_ovf <= 1'b1;
      if (clr) r_cnt <= '0;
      else if (r_vld_p3 && out_ready) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid  = r_vld_p3;
  assign y          = r_y_p3;
  assign ovf        = r_ovf;
  assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_lift53_step_pipe.sv
// Scoreboard bench for lift53_step_pipe: a 24-bit wrapping engine plus two 8-bit engines
// (saturating and wrapping) for range-limit behaviour.
module tb_lift53_step_pipe;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_valid8 = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [23:0] x_left = '0;
  logic signed [23:0] x_center = '0;
  logic signed [23:0] x_right = '0;
  logic               edge_l = 1'b0;
  logic               edge_r = 1'b0;
  logic               even_odd = 1'b0;
  logic               fwd_inv = 1'b0;

  logic               in_ready, out_valid, ovf;
  logic signed [23:0] y;
  logic [15:0]        sample_cnt;

  logic               in_ready8s, out_valid8s, ovf8s;
  logic signed [7:0]  y8s;
  logic [15:0]        cnt8s;
  logic               in_ready8w, out_valid8w, ovf8w;
  logic signed [7:0]  y8w;
  logic [15:0]        cnt8w;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint exp_q[$];
  bit     sb_ovf;

  always #5 clk = ~clk;

  lift53_step_pipe #(.W(24), .SAT(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .x_left(x_left), .x_center(x_center), .x_right(x_right),
    .edge_l(edge_l), .edge_r(edge_r), .even_odd(even_odd), .fwd_inv(fwd_inv),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .sample_cnt(sample_cnt));

  lift53_step_pipe #(.W(8), .SAT(1'b1), .CNT_W(16)) dut8s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid8), .in_ready(in_ready8s),
    .x_left(x_left[7:0]), .x_center(x_center[7:0]), .x_right(x_right[7:0]),
    .edge_l(edge_l), .edge_r(edge_r), .even_odd(even_odd), .fwd_inv(fwd_inv),
    .out_valid(out_valid8s), .out_ready(1'b1), .y(y8s), .ovf(ovf8s), .sample_cnt(cnt8s));

  lift53_step_pipe #(.W(8), .SAT(1'b0), .CNT_W(16)) dut8w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid8), .in_ready(in_ready8w),
    .x_left(x_left[7:0]), .x_center(x_center[7:0]), .x_right(x_right[7:0]),
    .edge_l(edge_l), .edge_r(edge_r), .even_odd(even_odd), .fwd_inv(fwd_inv),
    .out_valid(out_valid8w), .out_ready(1'b1), .y(y8w), .ovf(ovf8w), .sample_cnt(cnt8w));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: 5/3 lifting step in 64-bit arithmetic, then reduced to w bits.
  function automatic longint model(input longint l, input longint c, input longint r,
                                   input bit el, input bit er, input bit eo, input bit fi,
                                   input int w, input bit sat, output bit ov);
    longint ll, rr, t, res, mx, mn, md;
    ll = l;
    rr = r;
    if (el && er) begin ll = c; rr = c; end
    else if (el) ll = r;
    else if (er) rr = l;
    if (eo) t = (ll + rr + 2) >>> 2;
    else    t = (ll + rr) >>> 1;
    if ((!eo && fi) || (eo && !fi)) res = c - t;
    else                            res = c + t;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -(64'sd1 <<< (w - 1));
    ov = (res > mx) || (res < mn);
    if (sat && res > mx) return mx;
    if (sat && res < mn) return mn;
    md = res & ((64'sd1 <<< w) - 1);
    if (md > mx) md = md - (64'sd1 <<< w);
    return md;
  endfunction

  // Called at posedge+1: presents a triple, waits for acceptance, leaves in_valid high.
  task automatic put(input longint l, input longint c, input longint r,
                     input bit el, input bit er, input bit eo, input bit fi, input longint exp);
    int k;
    x_left = 24'(l); x_center = 24'(c); x_right = 24'(r);
    edge_l = el; edge_r = er; even_odd = eo; fwd_inv = fi;
    in_valid = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 100) chk("accept_timeout", 0, 1);
    else exp_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic putm(input longint l, input longint c, input longint r,
                      input bit el, input bit er, input bit eo, input bit fi);
    bit ov;
    longint e;
    e = model(l, c, r, el, er, eo, fi, 24, 1'b0, ov);
    if (ov) sb_ovf = 1'b1;
    put(l, c, r, el, er, eo, fi, e);
  endtask

  task automatic send(input longint l, input longint c, input longint r,
                      input bit el, input bit er, input bit eo, input bit fi, input longint exp);
    put(l, c, r, el, er, eo, fi, exp);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("y", $signed(y), exp_q.pop_front());
    end
  end

  initial begin
    logic signed [23:0] rl, rc, rr;
    longint held_y;
    int lat;
    bit ov;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_y", y, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", sample_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Main function and edge extension with fixed expectations
    send(80, 120, 164, 0, 0, 0, 1, -2);
    send(80, -2, 164, 0, 0, 0, 0, 120);
    send(10, 100, -3, 0, 0, 1, 1, 102);
    send(10, 102, -3, 0, 0, 1, 0, 100);
    send(999, 120, 164, 1, 0, 0, 1, -44);
    send(80, 120, 7, 0, 1, 0, 1, 40);
    send(80, 120, 7, 1, 1, 0, 1, 0);
    drain();
    chk("ovf_clean", ovf, 0);
    chk("cnt_after_7", sample_cnt, 7);

    // 8-bit range limits: saturate vs wrap
    x_left = -128; x_right = -128; x_center = 127;
    edge_l = 0; edge_r = 0; even_odd = 0; fwd_inv = 1;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("sat_valid", out_valid8s, 1);
    chk("sat_y", $signed(y8s), model(-128, 127, -128, 0, 0, 0, 1, 8, 1'b1, ov));
    chk("sat_y_const", $signed(y8s), 127);
    chk("sat_ovf", ovf8s, 1);
    chk("wrap_y", $signed(y8w), -1);
    chk("wrap_ovf", ovf8w, 1);
    @(posedge clk); #1;
    pulse_clr();
    chk("clr_ovf8s", ovf8s, 0);
    chk("clr_ovf8w", ovf8w, 0);
    chk("clr_cnt8s", cnt8s, 0);
    chk("clr_cnt_main", sample_cnt, 0);

    // Back-to-back stream with downstream stall in cycles 4..8
    sb_ovf = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rl = 24'($urandom); rc = 24'($urandom); rr = 24'($urandom);
          putm(rl, rc, rr, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 12; cyc++) begin
          out_ready = !(cyc >= 4 && cyc <= 8);
          @(negedge clk);
          if (cyc >= 4 && cyc <= 8) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            if (cyc == 4) held_y = $signed(y);
            else chk("stall_y_hold", $signed(y), held_y);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_cnt", sample_cnt, 6);
    chk("stream_ovf", ovf, longint'(sb_ovf));

    // Reset with two triples in flight
    put(5, 6, 7, 0, 0, 0, 1, 0);
    put(8, 9, 10, 0, 0, 1, 1, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", y, 0);
    chk("midrst_cnt", sample_cnt, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    putm(80, 120, 164, 0, 0, 0, 1);
    in_valid = 1'b0;
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("post_rst_latency", lat, 3);
    drain();
    chk("post_rst_cnt", sample_cnt, 1);
    chk("post_rst_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
